// File: rtl/rgb2yuv_stream.sv
// rgb2yuv_stream: 3-stage full-range BT.601 RGB->YUV (Q8) converter with valid/ready and line framing.
// Define RGB2YUV_422_EN to pair pixels within a line and average their chroma (4:2:2).
module rgb2yuv_stream #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_r,
  input  logic [W-1:0] in_g,
  input  logic [W-1:0] in_b,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_y,
  output logic [W-1:0] out_u,
  output logic [W-1:0] out_v,
  output logic         out_last
);
  localparam int IW = 2 * W + 10;
  typedef logic signed [IW-1:0] s_t;
  localparam s_t OFF = s_t'(1) <<< (W - 1);
  localparam s_t MAX = (s_t'(1) <<< W) - s_t'(1);
  localparam s_t RND = s_t'(128);
  function automatic s_t mul(input logic [W-1:0] x, input int c);
    return s_t'(c) * s_t'({1'b0, x});
  endfunction
  function automatic logic [W-1:0] sat(input s_t s, input s_t off);
    s_t t;
    t = (s >>> 8) + off;
    return t[IW-1] ? '0 : (t > MAX ? '1 : t[W-1:0]);
  endfunction
  logic v1, v2, v3, l1, l2, ld1, ld2, ld3, fire;
  s_t p [9];
  s_t sy, su, sv;
  logic [W-1:0] yc, uc, vc;
  // each stage loads when empty or when the stage after it frees up this cycle
  always_comb begin
    fire = out_valid && out_ready;
    ld3 = v2 && (!v3 || fire);
    ld2 = v1 && (!v2 || ld3);
    in_ready = !v1 || ld2;
    ld1 = in_valid && in_ready;
    yc = sat(sy, '0);
    uc = sat(su, OFF);
    vc = sat(sv, OFF);
  end
`ifdef RGB2YUV_422_EN
  logic hold, par, rel;
  logic [W-1:0] eu, ev, ua, va;
  // even pixel waits in stage 3 until its partner sits in stage 2; both then carry the averaged chroma
  always_comb begin
    rel = v3 && hold && v2;
    ua = W'(({1'b0, eu} + {1'b0, uc} + (W+1)'(1)) >> 1);
    va = W'(({1'b0, ev} + {1'b0, vc} + (W+1)'(1)) >> 1);
  end
  assign out_valid = v3 && !hold;
`else
  assign out_valid = v3;
`endif
  always_ff @(posedge clk) begin
    if (ld1) begin
      p[0] <= mul(in_r, 77);
      p[1] <= mul(in_g, 150);
      p[2] <= mul(in_b, 29);
      p[3] <= mul(in_r, 43);
      p[4] <= mul(in_g, 85);
      p[5] <= mul(in_b, 128);
      p[6] <= mul(in_r, 128);
      p[7] <= mul(in_g, 107);
      p[8] <= mul(in_b, 21);
      l1 <= in_last;
    end
    if (ld2) begin
      sy <= p[0] + p[1] + p[2] + RND;
      su <= p[5] - p[3] - p[4] + RND;
      sv <= p[6] - p[7] - p[8] + RND;
      l2 <= l1;
    end
    if (rst) begin
      {v1, v2, v3, out_last} <= '0;
      out_y <= '0;
      out_u <= '0;
      out_v <= '0;
`ifdef RGB2YUV_422_EN
      hold <= 1'b0;
      par <= 1'b0;
`endif
    end else begin
      v1 <= ld1 || (v1 && !ld2);
      v2 <= ld2 || (v2 && !ld3);
      v3 <= ld3 || (v3 && !fire);
      if (ld3) begin
        out_y <= yc;
        out_last <= l2;
      end
`ifdef RGB2YUV_422_EN
      if (ld3) begin
        out_u <= par ? ua : uc;
        out_v <= par ? va : vc;
        eu <= uc;
        ev <= vc;
        hold <= !par && !l2;
        par <= !par && !l2;
      end else if (rel) begin
        out_u <= ua;
        out_v <= va;
        hold <= 1'b0;
      end
`else
      if (ld3) begin
        out_u <= uc;
        out_v <= vc;
      end
`endif
    end
  end
endmodule

// File: tb/tb_rgb2yuv_stream.sv
// tb_rgb2yuv_stream: directed checks of rgb2yuv_stream (W=8 main instance, W=10 clamp instance).
module tb_rgb2yuv_stream;
  logic clk = 1'b0, rst = 1'b1;
  logic in_valid = 1'b0, in_last = 1'b0, out_ready = 1'b0;
  logic [7:0] in_r = '0, in_g = '0, in_b = '0;
  logic in_ready, out_valid, out_last;
  logic [7:0] out_y, out_u, out_v;
  logic a_valid = 1'b0, a_ready, a_ovalid, a_olast;
  logic [9:0] a_r = '0, a_y, a_u, a_v;
  int tests = 0, failed = 0;
  int sent, rcv, k;
  logic stall;
  logic [7:0] hy;
  // {r, g, b, y, u, v}, expected values worked out by hand from the BT.601 Q8 formulas
  localparam logic [47:0] TAB [10] = '{
    48'h000000_008080, 48'hff0000_4d55ff, 48'h00ff00_952b15, 48'h0000ff_1dff6b,
    48'hffffff_ff8080, 48'hffff00_e20195, 48'h00ffff_b2ab01, 48'hff00ff_6ad5eb,
    48'h808080_808080, 48'h0a141e_12877a};
  always #5 clk = ~clk;
  rgb2yuv_stream #(.W(8)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_u(out_u), .out_v(out_v), .out_last(out_last));
  rgb2yuv_stream #(.W(10)) dut10 (
    .clk(clk), .rst(rst), .in_valid(a_valid), .in_ready(a_ready),
    .in_r(a_r), .in_g('0), .in_b('0), .in_last(1'b1),
    .out_valid(a_ovalid), .out_ready(1'b1),
    .out_y(a_y), .out_u(a_u), .out_v(a_v), .out_last(a_olast));
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
  task automatic chk_out(input string tag, input logic [47:0] e, input logic l);
    chk({tag, "_valid"}, 32'(out_valid), 1);
    chk({tag, "_y"}, 32'(out_y), 32'(e[23:16]));
    chk({tag, "_u"}, 32'(out_u), 32'(e[15:8]));
    chk({tag, "_v"}, 32'(out_v), 32'(e[7:0]));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
  endtask
  task automatic drive(input logic [47:0] e, input logic l);
    in_valid = 1'b1;
    in_r = e[47:40];
    in_g = e[39:32];
    in_b = e[31:24];
    in_last = l;
  endtask
  task automatic put(input logic [47:0] e, input logic l);
    int t = 0;
    drive(e, l);
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("put_accept", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask
`ifdef RGB2YUV_422_EN
  localparam logic [47:0] P422 [3] = '{48'h000000_4d408a, 48'h000000_95408a, 48'h000000_1dff6b};
`endif
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_y", 32'(out_y), 0);
    chk("rst_u", 32'(out_u), 0);
    chk("rst_v", 32'(out_v), 0);
    chk("rst_last", 32'(out_last), 0);
    chk("rst_w10_in_ready", 32'(a_ready), 1);
    rst = 1'b0;
    a_valid = 1'b1;
    a_r = 10'd1023;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      a_valid = 1'b0;
      if (i < 3) chk("w10_lat_idle", 32'(a_ovalid), 0);
    end
    chk("w10_valid", 32'(a_ovalid), 1);
    chk("w10_y", 32'(a_y), 308);
    chk("w10_u", 32'(a_u), 340);
    chk("w10_v", 32'(a_v), 1023);
    chk("w10_last", 32'(a_olast), 1);
    out_ready = 1'b1;
    @(negedge clk);
    drive(TAB[4], 1'b0);
    @(negedge clk);
    drive(TAB[1], 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_out_valid", 32'(out_valid), 0);
    chk("midrst_in_ready", 32'(in_ready), 1);
    chk("midrst_y", 32'(out_y), 0);
    rst = 1'b0;
    repeat (6) begin
      @(negedge clk);
      chk("post_rst_no_stale", 32'(out_valid), 0);
    end
`ifdef RGB2YUV_422_EN
    put(TAB[1], 1'b0);
    put(TAB[2], 1'b0);
    put(TAB[3], 1'b1);
    k = 0;
    for (int t = 0; t < 20 && k < 3; t++) begin
      if (out_valid) begin
        chk_out("pair", P422[k], k == 2);
        k++;
      end
      @(negedge clk);
    end
    chk("pair_count", k, 3);
`else
    drive(TAB[0], 1'b0);
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (i < 3) chk("black_lat_idle", 32'(out_valid), 0);
    end
    chk_out("black", TAB[0], 1'b0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (i >= 3 && i <= 6) chk_out("prim", TAB[i - 2], 1'b0);
      else chk("prim_idle", 32'(out_valid), 0);
      if (i < 4) drive(TAB[i + 1], 1'b0);
      else in_valid = 1'b0;
    end
    out_ready = 1'b0;
    put(TAB[8], 1'b0);
    put(TAB[5], 1'b0);
    put(TAB[6], 1'b1);
    chk("full_in_ready", 32'(in_ready), 0);
    chk_out("stall0", TAB[8], 1'b0);
    @(negedge clk);
    chk("full_in_ready_hold", 32'(in_ready), 0);
    chk_out("stall1", TAB[8], 1'b0);
    out_ready = 1'b1;
    k = 0;
    for (int t = 0; t < 20 && k < 3; t++) begin
      if (out_valid) begin
        chk_out("drain", TAB[k == 0 ? 8 : (k == 1 ? 5 : 6)], k == 2);
        k++;
      end
      @(negedge clk);
    end
    chk("drain_count", k, 3);
    sent = 0;
    rcv = 0;
    stall = 1'b0;
    hy = '0;
    for (int c = 0; c < 400 && rcv < 10; c++) begin
      @(negedge clk);
      out_ready = 1'($urandom_range(0, 1));
      if (sent < 10) drive(TAB[sent], 1'b0);
      else in_valid = 1'b0;
      #1;
      if (stall) chk("bp_hold_y", 32'(out_y), 32'(hy));
      chk("bp_in_ready", 32'(in_ready), 32'(!((sent - rcv) == 3 && !out_ready)));
      if (out_valid && out_ready) begin
        chk_out("bp", TAB[rcv], 1'b0);
        rcv++;
      end
      stall = out_valid && !out_ready;
      hy = out_y;
      if (in_valid && in_ready) sent++;
    end
    chk("bp_count", rcv, 10);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
